// File: rtl/fsm_pkg.sv
// Shared state encoding and helpers for the serial pattern transmitter.
package fsm_pkg;

    // Transmitter states; encodings are visible on state_out
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Limit a requested length to the physical pattern width
    function automatic int unsigned clamp_len(input int unsigned req_len,
                                              input int unsigned max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register, MSB-first, zero fill from the bottom.
module shift_reg_piso #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load has priority over shift; zeros shift in so the register drains to 0
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    // Data register
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser = data_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter: loads a pattern on start and shifts it out
// MSB-first with a valid qualifier, optional repeats separated by idle gaps.
module pattern_tx
    import fsm_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 3,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_out
);

    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic [LEN_W-1:0] len_clamped;
    logic [REP_W-1:0] reps_eff;
    logic [WIDTH-1:0] pat_sel;
    logic [LEN_W-1:0] len_sel;

    assign len_clamped = LEN_W'(clamp_len(32'(len), WIDTH));
    assign reps_eff    = (reps == '0) ? REP_W'(1) : reps;

    // Fresh values on launch, latched copies on reload; left-align the low
    // len bits so the shifter's MSB is always the next bit to send
    always_comb begin
        pat_sel      = (state_q == ST_IDLE) ? pattern     : pattern_q;
        len_sel      = (state_q == ST_IDLE) ? len_clamped : len_q;
        sr_load_data = pat_sel << (WIDTH - 32'(len_sel));
    end

    // Next-state, counter and output-flag logic
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pattern_d = pattern;
                    len_d     = len_clamped;
                    bit_cnt_d = len_clamped;
                    rep_cnt_d = reps_eff;
                    if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                        sr_load = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == LEN_W'(1)) begin
                    if (rep_cnt_q > REP_W'(1)) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_W'(GAP);
                            sr_shift  = 1'b1;
                        end else begin
                            bit_cnt_d = len_q;
                            sr_load   = 1'b1;
                        end
                    end else begin
                        state_d  = ST_DONE;
                        sr_shift = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    sr_shift  = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = len_q;
                    sr_load   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_SHIFT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, counters and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Serializer; drains to zero so out is low whenever valid is low
    shift_reg_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_load_data),
        .ser       (out)
    );

    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = 2'(state_q);

endmodule
